switch_input_queues: RTL

Per-input FIFO bank that sits directly upstream of the switch round-robin arbiter. It buffers packets arriving on N switch inputs, presents a request vector (one bit per non-empty queue) to the arbiter, and consumes the arbiter's one-hot grant in the same cycle. On that grant it pops the head of the granted queue into a registered single-output stage with valid/ready backpressure.

---
 rtl/switch_input_queues.sv | 121 ++++++++++++
 1 files changed

// File: rtl/switch_input_queues.sv
// switch_input_queues
//   Per-input FIFO bank in front of the switch round-robin arbiter. Each of
//   the N inputs owns a DEPTH-entry circular buffer. A request vector is
//   presented to the arbiter (one bit per non-empty queue while the output
//   stage can take a word), and the arbiter's one-hot grant pops the granted
//   queue head into a registered valid/ready output stage in the same cycle.
//
// Ports
//   clk, rst             clock (rising edge), asynchronous active-high reset
//   in_valid/in_data     per-input push; input i uses in_data[i*W +: W]
//   in_ready             per-input accept (queue not full, not in reset)
//   req                  request vector to the arbiter
//   grant, any_grant     grant vector and any-grant flag from the arbiter
//   out_valid/out_data   registered output word
//   out_src              index of the queue the output word came from
//   out_ready            downstream accept
//   err                  sticky protocol-error flag (cleared only by rst)
module switch_input_queues #(
    parameter int N     = 8,
    parameter int S     = 3,
    parameter int W     = 32,
    parameter int DEPTH = 4,
    parameter int A     = 2
) (
    input  logic           clk,
    input  logic           rst,
    input  logic [N-1:0]   in_valid,
    input  logic [N*W-1:0] in_data,
    output logic [N-1:0]   in_ready,
    output logic [N-1:0]   req,
    input  logic [N-1:0]   grant,
    input  logic           any_grant,
    output logic           out_valid,
    output logic [W-1:0]   out_data,
    output logic [S-1:0]   out_src,
    input  logic           out_ready,
    output logic           err
);

    localparam logic [A:0] FULL = (A+1)'(DEPTH);

    logic [W-1:0] mem    [N][DEPTH];
    logic [A-1:0] rd_ptr [N];
    logic [A-1:0] wr_ptr [N];
    logic [A:0]   count  [N];

    logic         out_free;
    logic [N-1:0] sel;
    logic [N-1:0] push;
    logic [N-1:0] pop;
    logic [S-1:0] pop_idx;
    logic         pop_any;
    logic         err_now;

    always_comb begin
        out_free = ~out_valid | out_ready;
        for (int i = 0; i < N; i++) begin
            in_ready[i] = (count[i] != FULL) & ~rst;
            req[i]      = (count[i] != '0) & out_free;
        end
        push = in_valid & in_ready;
        // Grant bits without a matching request are simply dropped here.
        sel     = grant & req;
        pop_any = |sel;
        // Isolate the lowest set bit so a multi-hot grant still pops one queue.
        pop     = sel & (~sel + 1'b1);
        pop_idx = '0;
        for (int i = N-1; i >= 0; i--) begin
            if (sel[i]) pop_idx = S'(i);
        end
        err_now = ((sel & (sel - 1'b1)) != '0)
                | ((grant & ~req) != '0)
                | (any_grant != pop_any);
    end

    // Storage needs no reset: counts alone decide what is valid.
    always_ff @(posedge clk) begin
        for (int i = 0; i < N; i++) begin
            if (push[i]) mem[i][wr_ptr[i]] <= in_data[i*W +: W];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < N; i++) begin
                rd_ptr[i] <= '0;
                wr_ptr[i] <= '0;
                count[i]  <= '0;
            end
        end else begin
            for (int i = 0; i < N; i++) begin
                if (push[i]) wr_ptr[i] <= wr_ptr[i] + 1'b1;
                if (pop[i])  rd_ptr[i] <= rd_ptr[i] + 1'b1;
                case ({push[i], pop[i]})
                    2'b10:   count[i] <= count[i] + 1'b1;
                    2'b01:   count[i] <= count[i] - 1'b1;
                    default: count[i] <= count[i];
                endcase
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_src   <= '0;
            err       <= 1'b0;
        end else begin
            if (pop_any) begin
                out_valid <= 1'b1;
                out_data  <= mem[pop_idx][rd_ptr[pop_idx]];
                out_src   <= pop_idx;
            end else if (out_ready & out_valid) begin
                out_valid <= 1'b0;
            end
            if (err_now) err <= 1'b1;
        end
    end

endmodule
